// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and constants for the fifo read-side stream logic.
//   DEFAULT_WIDTH : default data width, must match the fifo WIDTH
//   BUF_DEPTH     : output buffer entries (fixed at 2)
//   occ_t         : output buffer fill count (0..2)
//   data_t        : data word at the default width
//   occ_next_f    : next fill count in 3-bit arithmetic so over/underflow is visible
package fifo_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned BUF_DEPTH     = 2;
  localparam int unsigned OCC_W         = 2;
  localparam int unsigned OCC_SUM_W     = 3;
  localparam int unsigned CNT_W         = 16;

  typedef logic [OCC_W-1:0]         occ_t;
  typedef logic [DEFAULT_WIDTH-1:0] data_t;

  // occ + inc - dec, widened so a value of 3 or a wrap to 7 can be detected
  function automatic logic [OCC_SUM_W-1:0] occ_next_f(input occ_t occ, input logic inc,
                                                      input logic dec);
    return OCC_SUM_W'({1'b0, occ}) + OCC_SUM_W'(inc) - OCC_SUM_W'(dec);
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: 2-entry circular output buffer with push/pop and fill tracking.
//   clk, arst      : clock, asynchronous active-high reset
//   push           : write push_data into the tail entry this edge
//   push_data      : word to store
//   ready          : downstream accept; pop_c = valid && ready
//   valid          : buffer holds at least one word
//   data           : head entry (always a register, never a bypass)
//   occ            : entries currently held (0..2)
//   occ_next_c     : occ + push - pop_c in 3-bit arithmetic
//   pop_c          : head is consumed at this edge
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 ready,
  output logic                 valid,
  output logic [WIDTH-1:0]     data,
  output occ_t                 occ,
  output logic [OCC_SUM_W-1:0] occ_next_c,
  output logic                 pop_c
);

  logic [WIDTH-1:0] entry [BUF_DEPTH];
  logic             head;
  logic             tail;
  occ_t             occ_q;

  assign valid      = (occ_q != '0);
  assign pop_c      = valid && ready;
  assign occ_next_c = occ_next_f(occ_q, push, pop_c);
  assign data       = entry[head];
  assign occ        = occ_q;

  // Storage and indices; single-bit indices wrap 1->0 by inversion
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      entry[0] <= '0;
      entry[1] <= '0;
      head     <= 1'b0;
      tail     <= 1'b0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        entry[tail] <= push_data;
        tail        <= ~tail;
      end
      if (pop_c) begin
        head <= ~head;
      end
      occ_q <= OCC_W'(occ_next_c);
    end
  end

  // Fill count must stay within 0..2 (an underflow wraps to 7 and is caught too)
  always @(posedge clk) begin
    if (!arst) begin
      assert (occ_next_c <= OCC_SUM_W'(BUF_DEPTH))
        else $error("fifo_skid_buf: occupancy out of range (%0d)", occ_next_c);
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains the synchronous fifo read port into a valid/ready stream.
// Reads are issued only when the 2-entry output buffer is guaranteed to have room
// for the word returning one cycle later, so the stream sustains one beat per clock.
//   clk, arst     : clock, asynchronous active-high reset
//   fifo_empty    : fifo empty flag
//   fifo_data_out : fifo read data, valid the cycle after fifo_rd_en
//   fifo_rd_en    : fifo read strobe (combinational, depends on m_ready)
//   m_valid       : stream data valid
//   m_ready       : downstream accept
//   m_data        : stream data (from a buffer register)
//   occupancy     : entries held in the output buffer (0..2)
//   beat_cnt      : 16-bit wrapping count of accepted beats
//                   (present only when FIFO_RD_STREAM_BEAT_CNT_EN is defined)
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned BUF_DEPTH = fifo_pkg::BUF_DEPTH
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data_out,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       occupancy
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
  ,
  output logic [CNT_W-1:0] beat_cnt
`endif
);

  // The issue rule below is only correct for a 2-entry buffer
  if (BUF_DEPTH != 2) begin : g_bad_depth
    $error("fifo_rd_stream: BUF_DEPTH must be 2");
  end

  logic                 inflight;
  logic                 pop_c;
  logic [OCC_SUM_W-1:0] occ_next_c;
  occ_t                 occ;

  fifo_skid_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk        (clk),
    .arst       (arst),
    .push       (inflight),
    .push_data  (fifo_data_out),
    .ready      (m_ready),
    .valid      (m_valid),
    .data       (m_data),
    .occ        (occ),
    .occ_next_c (occ_next_c),
    .pop_c      (pop_c)
  );

  assign occupancy = occ;

  // Issue a read only if the word it returns next cycle will still find a free entry
  assign fifo_rd_en = !arst && !fifo_empty && (occ_next_c < OCC_SUM_W'(BUF_DEPTH));

  // A read issued this cycle lands in the buffer at the next edge
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
  // Accepted-beat counter, wraps naturally at 16 bits
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      beat_cnt <= '0;
    end else if (pop_c) begin
      beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: self-checking bench for fifo_rd_stream.
// A behavioural fifo feeds the DUT; every word expected on the stream is queued
// when loaded and compared in order as beats are accepted.
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data_out = 8'h00;
  logic       fifo_rd_en;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic [1:0] occupancy;
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
  logic [15:0] beat_cnt;
`endif

  logic [7:0] fifo_q [$];
  logic [7:0] exp_q [$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         exp_beats = 0;

  always #5 clk = ~clk;

  fifo_rd_stream #(
    .WIDTH     (8),
    .BUF_DEPTH (2)
  ) dut (
    .clk           (clk),
    .arst          (arst),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_rd_en    (fifo_rd_en),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .occupancy     (occupancy)
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
    ,
    .beat_cnt      (beat_cnt)
`endif
  );

  // Load a word into the behavioural fifo; optionally expect it on the stream
  task automatic push_word(input logic [7:0] d, input logic expect_out);
    fifo_q.push_back(d);
    fifo_empty = 1'b0;
    if (expect_out) exp_q.push_back(d);
  endtask

  // One clock: the fifo answers a sampled read, then m_ready is set for the next cycle.
  // On return outputs are stable for observation until the next rising edge.
  task automatic advance(input logic rdy);
    logic rd;
    #1;
    rd = fifo_rd_en;
    @(posedge clk);
    #1;
    if (rd && fifo_q.size() != 0) fifo_data_out = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    @(negedge clk);
    m_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    push_word(8'h11, 1'b1);
    push_word(8'h22, 1'b1);
    @(negedge clk);
    m_ready = 1'b1;
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || occupancy !== 2'd0 || m_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b occ=%0d data=%h, want 0/0/00", m_valid, occupancy, m_data);
    end
    n_checks++;
    if (fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rd_forced: rd_en=%b, want 0", fifo_rd_en);
    end
    arst = 1'b0;
    #1;
    n_checks++;
    if (fifo_rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_rd: rd_en=%b, want 1", fifo_rd_en);
    end
    advance(1'b1);
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_latency: valid=%b one cycle after rd_en, want 0", m_valid);
    end
    for (int c = 0; c < 3; c++) begin
      advance(1'b1);
      if (c < 2) begin
        n_checks++;
        if (m_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL reset_beat_valid: cycle %0d valid=%b, want 1", c, m_valid);
        end
      end
      if (m_valid && m_ready) begin
        n_checks++;
        exp_beats++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL reset_extra_beat: data=%h with nothing expected", m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin
            n_fail++;
            $display("FAIL reset_data: got %h, want %h", m_data, e);
          end
        end
      end
      n_checks++;
      if (fifo_rd_en !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_rd_when_empty: rd_en=%b, want 0", fifo_rd_en);
      end
    end
  endtask

  task automatic test_stream8();
    logic [7:0] e;
    int rd_cnt = 0;
    int beats = 0;
    int first = -1;
    int last = -1;
    for (int i = 0; i < 8; i++) push_word(8'(i), 1'b1);
    #1;
    for (int c = 0; c < 14; c++) begin
      if (fifo_rd_en) rd_cnt++;
      if (m_valid && m_ready) begin
        n_checks++;
        exp_beats++;
        beats++;
        if (first < 0) first = c;
        last = c;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL stream_extra_beat: data=%h with nothing expected", m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin
            n_fail++;
            $display("FAIL stream_data: got %h, want %h", m_data, e);
          end
        end
      end
      advance(1'b1);
    end
    n_checks++;
    if (rd_cnt != 8) begin
      n_fail++;
      $display("FAIL stream_rd_count: got %0d, want 8", rd_cnt);
    end
    n_checks++;
    if (beats != 8 || last - first != 7) begin
      n_fail++;
      $display("FAIL stream_back_to_back: beats=%0d span=%0d, want 8/7", beats, last - first);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_missing: %0d words never delivered, want 0", exp_q.size());
    end
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
    n_checks++;
    if (beat_cnt !== 16'(exp_beats)) begin
      n_fail++;
      $display("FAIL beat_cnt: got %0d, want %0d", beat_cnt, exp_beats);
    end
`endif
  endtask

  task automatic test_stall();
    logic [7:0] e;
    @(negedge clk);
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'h30 + 8'(i), 1'b1);
    for (int c = 0; c < 5; c++) advance(1'b0);
    n_checks++;
    if (occupancy !== 2'd2 || m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_fill: occ=%0d valid=%b, want 2/1", occupancy, m_valid);
    end
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (fifo_rd_en !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'h30) begin
        n_fail++;
        $display("FAIL stall_hold: cycle %0d rd=%b valid=%b data=%h, want 0/1/30",
                 c, fifo_rd_en, m_valid, m_data);
      end
      advance(1'b0);
    end
    for (int c = 0; c < 12; c++) begin
      advance(1'b1);
      if (m_valid && m_ready) begin
        n_checks++;
        exp_beats++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL stall_duplicate: data=%h with nothing expected", m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin
            n_fail++;
            $display("FAIL stall_drain_data: got %h, want %h", m_data, e);
          end
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_loss: %0d words never delivered, want 0", exp_q.size());
    end
  endtask

  task automatic test_toggle();
    logic [7:0] e;
    for (int i = 0; i < 6; i++) push_word(8'hA0 + 8'(i), 1'b1);
    for (int c = 0; c < 24; c++) begin
      advance(c % 2 == 0);
      n_checks++;
      if (occupancy > 2'd2) begin
        n_fail++;
        $display("FAIL toggle_occ: occ=%0d, want <= 2", occupancy);
      end
      if (m_valid && m_ready) begin
        n_checks++;
        exp_beats++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL toggle_extra_beat: data=%h with nothing expected", m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin
            n_fail++;
            $display("FAIL toggle_data: got %h, want %h", m_data, e);
          end
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL toggle_missing: %0d words never delivered, want 0", exp_q.size());
    end
  endtask

  task automatic test_empty();
    for (int c = 0; c < 10; c++) begin
      advance(1'b1);
      n_checks++;
      if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL empty_idle: cycle %0d rd=%b valid=%b, want 0/0", c, fifo_rd_en, m_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    advance(1'b0);
    push_word(8'h5A, 1'b0);
    #1;
    n_checks++;
    if (fifo_rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_rd: rd_en=%b, want 1", fifo_rd_en);
    end
    advance(1'b0);
    arst = 1'b1;
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || occupancy !== 2'd0 || fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_state: valid=%b occ=%0d rd=%b, want 0/0/0", m_valid, occupancy, fifo_rd_en);
    end
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
    n_checks++;
    if (beat_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL midrst_beat_cnt: got %0d, want 0", beat_cnt);
    end
`endif
    advance(1'b0);
    arst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      advance(1'b1);
      n_checks++;
      if (m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_discard: cycle %0d valid=%b data=%h, want valid 0", c, m_valid, m_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream8();
    test_stall();
    test_toggle();
    test_empty();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side drain engine for the team's synchronous fifo: owns the fifo read port (rd_en, data_out, empty).
- Re-presents fifo data as a valid/ready stream with back-pressure.
- Holds data in a 2-entry output buffer so the stream runs at one beat per clock despite the fifo's 1-cycle read latency.
- Sits between the fifo and any downstream consumer. Read order is preserved.

Parameters:
- WIDTH, 8, data width; must match the fifo WIDTH.
- BUF_DEPTH, 2, output buffer entries; fixed at 2; any other value is a compile-time error.

Ports:
- clk  input  1  single clock, rising edge.
- arst  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  fifo empty flag.
- fifo_data_out  input  WIDTH  fifo read data; valid the cycle after rd_en.
- fifo_rd_en  output  1  fifo read strobe.
- m_valid  output  1  stream data valid.
- m_ready  input  1  downstream accept.
- m_data  output  WIDTH  stream data.
- occupancy  output  2  entries currently held in the output buffer (0..2).

Behaviour:
- Reset (arst high, asynchronous):
  - occupancy=0, inflight=0, m_valid=0, m_data=0, both buffer entries=0.
  - fifo_rd_en is forced to 0 combinationally while arst is high.
- State:
  - inflight (1 bit): a read was issued last cycle.
  - occ (0..2): output buffer fill.
  - head/tail index (1 bit each), wrapping 1->0.
- pop = m_valid && m_ready.
- Read issue: fifo_rd_en = !arst && !fifo_empty && (occ + inflight - pop) < 2. This is combinational in m_ready.
- Capture: when inflight=1, fifo_data_out is written into the tail entry at that clock edge, and tail advances.
- Read latency: fifo_rd_en at cycle N gives data at the fifo output in N+1, and m_valid=1 no earlier than N+2.
- Throughput: 1 beat/clock sustained when fifo is non-empty and m_ready=1.
- occ next value = occ + inflight - pop, using 3-bit arithmetic internally.
  - Never exceeds 2; never underflows.
  - An assertion checks both bounds.
- m_valid = (occ != 0). m_data = entry[head]. head advances on pop.
- Stability: while m_valid && !m_ready, m_data and m_valid hold for every cycle.
- Simultaneous capture and pop:
  - occ unchanged.
  - Both indices advance.
  - When occ=1 before the edge, the captured data becomes the new head in the next cycle.
- Boundary conditions:
  - fifo_empty=1: no rd_en. fifo_rd_en is never asserted while fifo_empty=1.
  - Buffer full (occ=2) and m_ready=0: no rd_en.
  - occ=1 with inflight=1 and no pop: rd_en is blocked.
- Reset mid-operation:
  - An in-flight read is discarded.
  - The data word it consumed is lost.
  - The fifo is reset together with this block by design.
- No combinational path from fifo_data_out to any output; m_data is always driven from a buffer register.

Optional Feature:
- Macro FIFO_RD_STREAM_BEAT_CNT_EN.
- Defined:
  - Adds output beat_cnt, 16 bits.
  - Increments by 1 on every pop and wraps 0xFFFF->0x0000.
  - Resets to 0 on arst.
- Undefined:
  - Port and counter are absent.
  - No other behaviour change.

Decomposition:
- Shared package fifo_pkg:
  - default WIDTH constant.
  - typedef occ_t (logic [1:0]).
  - localparam BUF_DEPTH=2.
  - typedef data_t parameterised by WIDTH via a package-level default.
- One natural sub-module, fifo_skid_buf: the 2-entry buffer with head/tail/occ logic and a push/pop interface.
- The top level holds the read-issue and inflight logic.

Test Plan:
- Reset with fifo holding 0x11,0x22: release arst, m_ready=1 -> fifo_rd_en in the first cycle; m_valid with 0x11 two cycles later, 0x22 the next cycle; no rd_en once fifo_empty=1.
- Stream 8 words 0x00..0x07, m_ready=1 throughout -> 8 consecutive beats in order; exactly 8 rd_en pulses.
- m_ready=0 while streaming -> exactly 2 words are buffered (occupancy=2) and fifo_rd_en stays 0. m_data holds its value unchanged for 5 stall cycles. Raising m_ready drains with no loss or duplication.
- m_ready toggling 1,0,1,0 with fifo holding 0xA0..0xA5 -> output sequence is exactly 0xA0..0xA5; occupancy never reads 3.
- fifo_empty=1 for 10 cycles with occupancy=0 -> fifo_rd_en=0 and m_valid=0 throughout.
- Assert arst in the cycle after rd_en, capturing 0x5A -> m_valid=0 and occupancy=0 immediately; 0x5A is never presented. With the macro defined, beat_cnt=0.
